// File: rtl/wb_uart_sched.sv
// wb_uart_sched: Wishbone master that polls the UART status register, drains RX
// bytes to a single consumer and writes TX bytes from two round-robin requesters.
module wb_uart_sched #(
  parameter logic [31:0] base_adr    = 32'h0,
  parameter int unsigned ack_timeout = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_err,
  output logic        bus_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {IDLE, POLL, DECIDE, RXRD, TXWR, HOLD} state_t;

  localparam logic [31:0] DATA_ADR     = base_adr + 32'd4;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(ack_timeout - 1);

  state_t      state, state_d;
  logic [7:0]  ucr, ucr_d;
  logic        last, last_d;
  logic        grant, grant_d;
  logic [7:0]  timer, timer_d;
  logic        hold_cnt, hold_cnt_d;
  logic        hold_bus;
  logic        cyc_d, we_d;
  logic [31:0] adr_d, dat_d;
  logic [3:0]  sel_d;
  logic        req0_ready_d, req1_ready_d, rx_valid_d, bus_err_d, rx_err_d;
  logic [7:0]  rx_data_d;
  logic        timed_out, any_req, pick;
  logic        unused_bits;

  assign timed_out   = (timer == TIMEOUT_LAST);
  assign any_req     = req0_valid | req1_valid;
  assign pick        = (req0_valid && req1_valid) ? ~last : req1_valid;
  assign wb_stb_o    = wb_cyc_o;
  assign unused_bits = ^{wb_dat_i[31:8], ucr[7:5], ucr[3:2]};

  // State, bookkeeping and every output are registered here; reset abandons any bus cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ucr        <= 8'd0;
      last       <= 1'b1;
      grant      <= 1'b0;
      timer      <= 8'd0;
      hold_cnt   <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= 32'd0;
      wb_sel_o   <= 4'd0;
      wb_dat_o   <= 32'd0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'd0;
      rx_err     <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_d;
      ucr        <= ucr_d;
      last       <= last_d;
      grant      <= grant_d;
      timer      <= timer_d;
      hold_cnt   <= hold_cnt_d;
      wb_cyc_o   <= cyc_d;
      wb_we_o    <= we_d;
      wb_adr_o   <= adr_d;
      wb_sel_o   <= sel_d;
      wb_dat_o   <= dat_d;
      req0_ready <= req0_ready_d;
      req1_ready <= req1_ready_d;
      rx_valid   <= rx_valid_d;
      rx_data    <= rx_data_d;
      rx_err     <= rx_err_d;
      bus_err    <= bus_err_d;
    end
  end

  // Next state and next output values; the bus idles unless a cycle starts or is still waiting.
  always_comb begin
    state_d      = state;
    ucr_d        = ucr;
    last_d       = last;
    grant_d      = grant;
    timer_d      = 8'd0;
    hold_cnt_d   = hold_cnt;
    hold_bus     = 1'b0;
    cyc_d        = 1'b0;
    we_d         = 1'b0;
    adr_d        = 32'd0;
    sel_d        = 4'd0;
    dat_d        = 32'd0;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data;
    rx_err_d     = rx_err;
    bus_err_d    = 1'b0;

    case (state)
      IDLE: begin
        if (any_req || rx_ready) begin
          cyc_d   = 1'b1;
          adr_d   = base_adr;
          sel_d   = 4'b1111;
          state_d = POLL;
        end
      end
      POLL: begin
        if (wb_ack_i) begin
          ucr_d   = wb_dat_i[7:0];
          state_d = DECIDE;
        end else if (timed_out) begin
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          hold_bus = 1'b1;
          timer_d  = timer + 8'd1;
        end
      end
      DECIDE: begin
        if (ucr[0] && rx_ready) begin
          cyc_d   = 1'b1;
          adr_d   = DATA_ADR;
          sel_d   = 4'b1111;
          state_d = RXRD;
        end else if (!ucr[4] && any_req) begin
          grant_d = pick;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = DATA_ADR;
          sel_d   = 4'b0001;
          dat_d   = {24'd0, (pick ? req1_data : req0_data)};
          state_d = TXWR;
        end else begin
          state_d = IDLE;
        end
      end
      RXRD: begin
        if (wb_ack_i) begin
          rx_valid_d = 1'b1;
          rx_data_d  = wb_dat_i[7:0];
          rx_err_d   = ucr[1];
          state_d    = IDLE;
        end else if (timed_out) begin
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          hold_bus = 1'b1;
          timer_d  = timer + 8'd1;
        end
      end
      TXWR: begin
        if (wb_ack_i) begin
          req0_ready_d = ~grant;
          req1_ready_d = grant;
          last_d       = grant;
          hold_cnt_d   = 1'b0;
          state_d      = HOLD;
        end else if (timed_out) begin
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          hold_bus = 1'b1;
          timer_d  = timer + 8'd1;
        end
      end
      HOLD: begin
        if (hold_cnt) begin
          hold_cnt_d = 1'b0;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hold_bus) begin
      cyc_d = wb_cyc_o;
      we_d  = wb_we_o;
      adr_d = wb_adr_o;
      sel_d = wb_sel_o;
      dat_d = wb_dat_o;
    end
  end

endmodule
